// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the multi-channel switch debouncer.
//   state_t   : per-channel debounce FSM state (IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO)
//   calc_dvsr : clock cycles per sample tick for a given clock rate and period
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  // Cycles per sample tick. Divide first so large clock rates stay in 32 bits.
  function automatic int calc_dvsr(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One switch channel: 2-flop synchroniser, four-state debounce FSM with a
// stable-tick counter, registered level and edge pulses. With the macro
// DEBOUNCE_LONG_PRESS_EN defined, a hold counter also produces a one-shot
// long-press pulse; otherwise long_press is tied low.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   tick       in   one-cycle sample strobe from the shared prescaler
//   sw_in      in   raw asynchronous switch input
//   sw_out     out  debounced level (registered)
//   rise       out  one-cycle pulse on accepted 0->1
//   fall       out  one-cycle pulse on accepted 1->0
//   long_press out  one-cycle pulse after LONG_TICKS ticks held high
// -----------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 2,
  parameter int LONG_TICKS   = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sw_in,
  output logic sw_out,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_TICKS);

  logic [1:0]    sync_reg;
  logic          s;
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
  logic          sw_out_reg, sw_out_next;
  logic          rise_reg, rise_next;
  logic          fall_reg, fall_next;

  assign s       = sync_reg[1];
  assign cnt_inc = cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg   <= '0;
      state_reg  <= IDLE_LO;
      cnt_reg    <= '0;
      sw_out_reg <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[0], sw_in};
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sw_out_reg <= sw_out_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
    end
  end

  // The revert test comes before the tick test in the WAIT states, so a
  // level that drops back on the accepting tick is still rejected.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      IDLE_LO: begin
        if (s) begin
          state_next = WAIT_HI;
          cnt_next   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_next = IDLE_LO;
        end else if (tick) begin
          cnt_next = cnt_inc;
          if (cnt_inc == STABLE_MAX) begin
            state_next = IDLE_HI;
            rise_next  = 1'b1;
          end
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_next = WAIT_LO;
          cnt_next   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_next = IDLE_HI;
        end else if (tick) begin
          cnt_next = cnt_inc;
          if (cnt_inc == STABLE_MAX) begin
            state_next = IDLE_LO;
            fall_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE_LO;
    endcase
    // Level follows the state being entered so it changes with the pulse.
    sw_out_next = (state_next == IDLE_HI) || (state_next == WAIT_LO);
  end

  assign sw_out = sw_out_reg;
  assign rise   = rise_reg;
  assign fall   = fall_reg;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

  logic [HW-1:0] hold_reg;
  logic          long_reg;
  logic          holding;

  // WAIT_LO counts too, so a release bounce does not restart the hold time.
  assign holding = (state_reg == IDLE_HI) || (state_reg == WAIT_LO);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg <= '0;
      long_reg <= 1'b0;
    end else begin
      long_reg <= 1'b0;
      // Only a fresh press (from WAIT_HI) re-arms; saturation blocks repeats.
      if (state_reg == WAIT_HI && state_next == IDLE_HI) begin
        hold_reg <= '0;
      end else if (holding && tick && hold_reg != HOLD_MAX) begin
        hold_reg <= hold_reg + 1'b1;
        if (hold_reg + 1'b1 == HOLD_MAX) begin
          long_reg <= 1'b1;
        end
      end
    end
  end

  assign long_press = long_reg;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/multi_switch_debouncer.sv
// -----------------------------------------------------------------------------
// multi_switch_debouncer
// N_CH independent switch debouncers sharing one sample-tick prescaler.
// Optional long-press detection is built when DEBOUNCE_LONG_PRESS_EN is defined.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   sw_in      in   [N_CH] raw asynchronous switch inputs
//   sw_out     out  [N_CH] debounced levels
//   rise       out  [N_CH] one-cycle pulse on accepted 0->1
//   fall       out  [N_CH] one-cycle pulse on accepted 1->0
//   long_press out  [N_CH] one-cycle pulse after LONG_TICKS ticks held high
// -----------------------------------------------------------------------------
module multi_switch_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int DEBOUNCE_MS  = 10,
  parameter int STABLE_TICKS = 2,
  parameter int LONG_TICKS   = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] sw_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press
);

  localparam int DVSR = calc_dvsr(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int PW   = $clog2(DVSR);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DVSR - 1);

  logic [PW-1:0] presc_reg;
  logic          tick;

  assign tick = (presc_reg == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .sw_in     (sw_in[gi]),
      .sw_out    (sw_out[gi]),
      .rise      (rise[gi]),
      .fall      (fall[gi]),
      .long_press(long_press[gi])
    );
  end

endmodule
